seg7_count_checker: RTL and testbench
=====================================

# seg7_count_checker

Receive-side monitor for the 3-bit counter's 7-segment output: decodes the segment pattern back to a digit and checks the modulo-8 sequence. It locks onto the incoming pattern stream, counts sequence and decode errors, and re-publishes the recovered digit. It sits downstream of the counter/display path on the same board clock and is used for self-test of the counter and driver without visual inspection.

## Interface
- UP, 1: expected direction; 1 = +1 mod 8 per sample, 0 = −1 mod 8.
- ERR_W, 8: width of error counter.
- CLK  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- iValid  in  1  sample strobe; iDisplay is examined only in cycles where iValid=1.
- iDisplay  in  7  segment pattern, active-low, bit6..bit0 = g,f,e,d,c,b,a.
- iClrErr  in  1  synchronous clear of oErrCnt.
- oDigit  out  3  last successfully decoded digit.
- oLocked  out  1  sequence tracking established.
- oError  out  1  one-cycle pulse on a detected error.
- oErrCnt  out  ERR_W  saturating error count.

## Operation
- Legal patterns (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000. Any other value is undecodable.
- States: HUNT, SYNC, LOCKED. Reset state HUNT.
- HUNT: valid sample with legal pattern → store digit, go SYNC. Illegal pattern → stay HUNT, no error.
- SYNC: legal pattern equal to stored+1 mod 8 (UP=1; −1 when UP=0) → LOCKED. Legal pattern otherwise → store new digit, stay SYNC, no error. Illegal → HUNT, no error.
- LOCKED: legal and expected → store, stay LOCKED. Legal but unexpected (including repeat of same digit) → oError, store new digit, go SYNC. Illegal → oError, go HUNT, oDigit holds.
- Wrap-around: 7→0 (UP=1) and 0→7 (UP=0) are expected steps.
- oErrCnt increments by 1 per oError, saturates at 2^ERR_W−1.
- iClrErr and an error in the same cycle: clear wins, oErrCnt=0.
- iValid=0: state, oDigit, oLocked unchanged; oError=0.
- oLocked=1 exactly when state is LOCKED.

## Timing
- All outputs registered; response to a sample at edge N appears after edge N (visible cycle N+1).
- Lock latency: two consecutive valid, legal, in-sequence samples; oLocked rises after the second.
- oError high exactly one cycle per offending sample; back-to-back bad samples give back-to-back pulses.
- Reset values: oDigit=0, oLocked=0, oError=0, oErrCnt=0, state HUNT.
- rst_n low mid-operation clears everything immediately (asynchronous), regardless of CLK; first sample after release is treated as in HUNT.
- iClrErr takes effect at the next rising edge, independent of iValid.

## Structure
- Shared package seg7_pkg: the eight segment pattern constants, state encoding (HUNT/SYNC/LOCKED), digit width constant 3.
- One combinational sub-module seg7_decode: 7-bit pattern in → 3-bit digit + legal flag out; reused by any future display readback.
- Top holds the state register, digit register, expected-next computation, and error counter.

## Test plan
- Reset, then valid patterns 0,1,2,…,7,0,1 (UP=1) → oLocked=1 after second sample, oError never set, oErrCnt=0, oDigit tracks, 7→0 accepted.
- Locked on 3, then pattern for 5 → oError pulse, oLocked=0, oDigit=5, oErrCnt=1; then 6 → oLocked=1 again.
- Locked, then illegal 1111111 → oError, state HUNT, oDigit holds previous value, oErrCnt+1; then 1111111 again → no further error.
- ERR_W=2: force five unexpected samples while locked/resyncing → oErrCnt saturates at 3; iClrErr coincident with an error → oErrCnt=0.
- UP=0, sequence 2,1,0,7,6 → locked, no errors; same bench with UP=1 → never locks.
- Assert rst_n low between clock edges while locked with oErrCnt=2 → all outputs 0 immediately; iValid gaps between samples leave state unchanged.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for 7-segment readback: active-low segment patterns, tracker states, digit width.
// Combinational only; no latency and no flow control.
package seg7_pkg;

   localparam int DIGIT_W = 3;
   localparam int SEG_W   = 7;

   // Active-low, bit6..bit0 = g,f,e,d,c,b,a
   localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   function automatic logic [DIGIT_W-1:0] next_digit(input logic [DIGIT_W-1:0] cur,
                                                     input logic             up);
      return up ? cur + DIGIT_W'(1) : cur - DIGIT_W'(1);
   endfunction

endpackage

// File: rtl/seg7_count_checker_if.sv
// Sample/result bundle between the segment stream source and the sequence checker.
// Checker outputs are registered; there is no backpressure on the sample strobe.
interface seg7_count_checker_if #(
   parameter int ERR_W = 8
);
   import seg7_pkg::*;

   logic                 iValid;
   logic [SEG_W-1:0]     iDisplay;
   logic                 iClrErr;
   logic [DIGIT_W-1:0]   oDigit;
   logic                 oLocked;
   logic                 oError;
   logic [ERR_W-1:0]     oErrCnt;

   modport master (
      output iValid, iDisplay, iClrErr,
      input  oDigit, oLocked, oError, oErrCnt
   );

   modport slave (
      input  iValid, iDisplay, iClrErr,
      output oDigit, oLocked, oError, oErrCnt
   );

endinterface

// File: rtl/seg7_decode.sv
// Maps an active-low 7-segment pattern back to its digit and flags patterns that match no digit.
// Purely combinational; no latency, no flow control.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0]   pattern,
   output logic [DIGIT_W-1:0] digit,
   output logic               legal
);

   always_comb begin
      digit = '0;
      legal = 1'b1;
      case (pattern)
         SEG_0:   digit = 3'd0;
         SEG_1:   digit = 3'd1;
         SEG_2:   digit = 3'd2;
         SEG_3:   digit = 3'd3;
         SEG_4:   digit = 3'd4;
         SEG_5:   digit = 3'd5;
         SEG_6:   digit = 3'd6;
         SEG_7:   digit = 3'd7;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_count_checker.sv
// Locks onto a modulo-8 7-segment stream, re-publishes the digit and counts sequence/decode errors.
// All outputs registered one cycle after the sampling edge; samples are always accepted.
module seg7_count_checker
   import seg7_pkg::*;
#(
   parameter bit UP    = 1'b1,
   parameter int ERR_W = 8
) (
   input  logic CLK,
   input  logic rst_n,
   seg7_count_checker_if.slave bus
);

   localparam logic [ERR_W-1:0] CNT_MAX = '1;

   state_t               state;
   logic [DIGIT_W-1:0]   digit_q;
   logic                 locked_q;
   logic                 error_q;
   logic [ERR_W-1:0]     cnt_q;

   logic [DIGIT_W-1:0]   dec_digit;
   logic                 dec_legal;
   logic [DIGIT_W-1:0]   expected;
   logic                 in_seq;
   logic                 err_now;

   seg7_decode u_decode (
      .pattern (bus.iDisplay),
      .digit   (dec_digit),
      .legal   (dec_legal)
   );

   assign expected = next_digit(digit_q, UP);
   assign in_seq   = dec_legal && (dec_digit == expected);

   // Only a broken stream that was already locked counts as an error.
   always_comb begin
      err_now = 1'b0;
      if (bus.iValid && state == ST_LOCKED) begin
         err_now = !in_seq;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_HUNT;
         digit_q  <= '0;
         locked_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         error_q <= err_now;
         if (bus.iValid) begin
            case (state)
               ST_HUNT: begin
                  if (dec_legal) begin
                     digit_q <= dec_digit;
                     state   <= ST_SYNC;
                  end
               end
               ST_SYNC: begin
                  if (!dec_legal) begin
                     state <= ST_HUNT;
                  end else if (in_seq) begin
                     digit_q  <= dec_digit;
                     state    <= ST_LOCKED;
                     locked_q <= 1'b1;
                  end else begin
                     digit_q <= dec_digit;
                  end
               end
               ST_LOCKED: begin
                  if (!dec_legal) begin
                     state    <= ST_HUNT;
                     locked_q <= 1'b0;
                  end else if (in_seq) begin
                     digit_q <= dec_digit;
                  end else begin
                     digit_q  <= dec_digit;
                     state    <= ST_SYNC;
                     locked_q <= 1'b0;
                  end
               end
               default: begin
                  state    <= ST_HUNT;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // Clear has priority over a coincident error.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (bus.iClrErr) begin
         cnt_q <= '0;
      end else if (err_now && cnt_q != CNT_MAX) begin
         cnt_q <= cnt_q + ERR_W'(1);
      end
   end

   assign bus.oDigit  = digit_q;
   assign bus.oLocked = locked_q;
   assign bus.oError  = error_q;
   assign bus.oErrCnt = cnt_q;

endmodule

// File: tb/tb_seg7_count_checker.sv
// Three checker variants (up/8-bit, down/8-bit, up/2-bit counter) fed the same stream, scoreboarded
// against a digit-level reference model.
module tb_seg7_count_checker;

   typedef struct packed {
      logic [2:0] dig;
      logic       lk;
      logic       er;
      logic [7:0] cnt;
   } exp_t;
   typedef exp_t [2:0] exp3_t;

   logic CLK   = 1'b0;
   logic rst_n = 1'b0;
   always #5 CLK = ~CLK;

   seg7_count_checker_if #(.ERR_W(8)) if0 ();
   seg7_count_checker_if #(.ERR_W(8)) if1 ();
   seg7_count_checker_if #(.ERR_W(2)) if2 ();

   seg7_count_checker #(.UP(1'b1), .ERR_W(8)) dut0 (.CLK(CLK), .rst_n(rst_n), .bus(if0));
   seg7_count_checker #(.UP(1'b0), .ERR_W(8)) dut1 (.CLK(CLK), .rst_n(rst_n), .bus(if1));
   seg7_count_checker #(.UP(1'b1), .ERR_W(2)) dut2 (.CLK(CLK), .rst_n(rst_n), .bus(if2));

   int    compared   = 0;
   int    mismatched = 0;
   exp3_t sb_q[$];
   event  chk_ev;

   // reference model state: 0 = hunting, 1 = one candidate seen, 2 = locked
   int m_st[3];
   int m_dig[3];
   int m_cnt[3];
   bit m_err[3];

   function automatic logic [6:0] pat_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         default: return 7'b1111000;
      endcase
   endfunction

   function automatic int decode_ref(input logic [6:0] p);
      for (int d = 0; d < 8; d++) if (pat_of(d) == p) return d;
      return -1;
   endfunction

   function automatic int step_of(input int i);
      return (i == 1) ? 7 : 1;
   endfunction

   function automatic int max_of(input int i);
      return (i == 2) ? 3 : 255;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_st[i] = 0; m_dig[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
      end
   endtask

   task automatic model_step(input bit v, input logic [6:0] p, input bit clr);
      int x;
      int nxt;
      x = decode_ref(p);
      for (int i = 0; i < 3; i++) begin
         nxt      = (m_dig[i] + step_of(i)) % 8;
         m_err[i] = 0;
         if (v) begin
            if (m_st[i] == 0) begin
               if (x >= 0) begin m_dig[i] = x; m_st[i] = 1; end
            end else if (x < 0) begin
               m_err[i] = (m_st[i] == 2);
               m_st[i]  = 0;
            end else if (x == nxt) begin
               m_dig[i] = x; m_st[i] = 2;
            end else begin
               m_err[i] = (m_st[i] == 2);
               m_dig[i] = x; m_st[i] = 1;
            end
         end
         if (clr) m_cnt[i] = 0;
         else if (m_err[i] && m_cnt[i] < max_of(i)) m_cnt[i]++;
      end
   endtask

   task automatic push_expected();
      exp3_t e;
      for (int i = 0; i < 3; i++) begin
         e[i].dig = 3'(m_dig[i]);
         e[i].lk  = (m_st[i] == 2);
         e[i].er  = m_err[i];
         e[i].cnt = 8'(m_cnt[i]);
      end
      sb_q.push_back(e);
   endtask

   task automatic set_in(input bit v, input logic [6:0] p, input bit clr);
      if0.iValid = v; if0.iDisplay = p; if0.iClrErr = clr;
      if1.iValid = v; if1.iDisplay = p; if1.iClrErr = clr;
      if2.iValid = v; if2.iDisplay = p; if2.iClrErr = clr;
   endtask

   task automatic cycle(input bit v, input logic [6:0] p, input bit clr);
      set_in(v, p, clr);
      @(posedge CLK);
      #1;
      if (!rst_n) model_reset();
      else model_step(v, p, clr);
      push_expected();
   endtask

   task automatic digit(input int d);
      cycle(1'b1, pat_of(d), 1'b0);
   endtask

   task automatic async_reset();
      @(negedge CLK);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      push_expected();
      -> chk_ev;
   endtask

   function automatic exp_t act_of(input int i);
      exp_t a;
      case (i)
         0: begin a.dig = if0.oDigit; a.lk = if0.oLocked; a.er = if0.oError; a.cnt = 8'(if0.oErrCnt); end
         1: begin a.dig = if1.oDigit; a.lk = if1.oLocked; a.er = if1.oError; a.cnt = 8'(if1.oErrCnt); end
         default: begin a.dig = if2.oDigit; a.lk = if2.oLocked; a.er = if2.oError; a.cnt = 8'(if2.oErrCnt); end
      endcase
      return a;
   endfunction

   task automatic cmp(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, i, act, exp, $time);
      end
   endtask

   initial begin
      exp3_t e;
      exp_t  a;
      forever begin
         @(negedge CLK or chk_ev);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int i = 0; i < 3; i++) begin
               a = act_of(i);
               cmp("digit",  i, 8'(a.dig), 8'(e[i].dig));
               cmp("locked", i, 8'(a.lk),  8'(e[i].lk));
               cmp("error",  i, 8'(a.er),  8'(e[i].er));
               cmp("errcnt", i, a.cnt,     e[i].cnt);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd;
      int dir;
      int r;
      logic [6:0] p;
      model_reset();
      set_in(1'b0, 7'h7f, 1'b0);
      repeat (3) cycle(1'b0, 7'h7f, 1'b0);
      rst_n = 1'b1;

      // full up sequence with wrap
      for (int k = 0; k < 10; k++) digit(k % 8);
      // locked on 3, skip to 5, then resume with 6
      digit(2); digit(3); digit(5); digit(6);
      // illegal pattern twice while locked
      digit(4); digit(5);
      cycle(1'b1, 7'h7f, 1'b0);
      cycle(1'b1, 7'h7f, 1'b0);
      // repeated breaks to saturate the narrow counter, then clear against an error
      cycle(1'b0, 7'h7f, 1'b1);
      digit(0); digit(1); digit(3); digit(4); digit(6); digit(7);
      digit(1); digit(2); digit(4); digit(5); digit(7); digit(0);
      cycle(1'b1, pat_of(5), 1'b1);
      cycle(1'b0, 7'h7f, 1'b0);
      // downward sequence
      digit(2); digit(1); digit(0); digit(7); digit(6);
      // two errors while locked, then asynchronous reset between edges
      cycle(1'b0, 7'h7f, 1'b1);
      digit(0); digit(1); digit(3); digit(4); digit(6); digit(7);
      async_reset();
      cycle(1'b1, pat_of(0), 1'b0);
      cycle(1'b0, 7'h7f, 1'b0);
      rst_n = 1'b1;
      // gaps between samples
      digit(3);
      cycle(1'b0, pat_of(6), 1'b0);
      digit(4);
      cycle(1'b0, 7'h00, 1'b0);
      cycle(1'b0, pat_of(1), 1'b0);
      digit(5);
      digit(7);
      cycle(1'b0, pat_of(0), 1'b0);

      // randomized stream: mostly counting, with direction flips, jumps, junk and clears
      rd  = 0;
      dir = 1;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 29) == 0) dir = 8 - dir;
         r = $urandom_range(0, 99);
         if (r < 80) begin
            rd = (rd + dir) % 8;
            p  = pat_of(rd);
         end else if (r < 90) begin
            rd = $urandom_range(0, 7);
            p  = pat_of(rd);
         end else begin
            p = 7'($urandom);
         end
         cycle($urandom_range(0, 3) != 0, p, $urandom_range(0, 24) == 0);
      end

      @(negedge CLK);
      #1;
      compared++;
      if (sb_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
